// File: rtl/play_judge.sv
// play_judge: rhythm-game judging engine.
// Fetches goal notes one at a time from the song store and shows each goal
// key on the LEDs. Grades the player's hit against a timing window around
// the note's target time, and accumulates score, combo and max-combo.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for en; all results cleared
// FETCH | requesting note rd_idx from the song store
// WAIT  | goal note on the LEDs; timing the player's hit
// GAP   | rest of rd_length * LEN_UNIT ticks after the judgement
// DONE  | song finished; results held until en drops
module play_judge #(
  parameter int KEYS        = 7,
  parameter int OCT_W       = 2,
  parameter int LEN_W       = 3,
  parameter int IDX_W       = 8,
  parameter int T_W         = 16,
  parameter int LEAD        = 64,
  parameter int LEN_UNIT    = 16,
  parameter int PERFECT_WIN = 4,
  parameter int GOOD_WIN    = 16,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int COMBO_CAP   = 15,
  parameter int SCORE_W     = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tick,
  input  logic [1:0]         difficulty,
  input  logic [IDX_W-1:0]   song_len,
  output logic               rd_req,
  output logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_valid,
  input  logic [KEYS-1:0]    rd_note,
  input  logic [OCT_W-1:0]   rd_octave,
  input  logic [LEN_W-1:0]   rd_length,
  input  logic               hit,
  input  logic [KEYS-1:0]    hit_key,
  input  logic [OCT_W-1:0]   hit_octave,
  output logic [KEYS-1:0]    note_led,
  output logic               judge_valid,
  output logic [1:0]         judge_grade,
  output logic [IDX_W-1:0]   combo,
  output logic [IDX_W-1:0]   max_combo,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Window arithmetic is done two bits wider than the tick timer so that
  // t + window and LEAD + window never wrap.
  localparam int E_W  = T_W + 2;
  localparam int S1_W = SCORE_W + 1;

  localparam logic [1:0] GR_MISS    = 2'd0;
  localparam logic [1:0] GR_GOOD    = 2'd1;
  localparam logic [1:0] GR_PERFECT = 2'd2;

  localparam logic [E_W-1:0]  LEAD_E = E_W'(LEAD);
  localparam logic [E_W-1:0]  PWIN_E = E_W'(PERFECT_WIN);
  localparam logic [E_W-1:0]  GWIN_E = E_W'(GOOD_WIN);
  localparam logic [S1_W-1:0] CAP_S  = S1_W'(COMBO_CAP);

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     len_q;
  logic [KEYS-1:0]      note_q;
  logic [OCT_W-1:0]     oct_q;
  logic [LEN_W-1:0]     nlen_q;
  logic [T_W-1:0]       t_q;
  logic [T_W-1:0]       gap_q;

  logic                 rd_req_q;
  logic [KEYS-1:0]      led_q;
  logic                 jv_q;
  logic [1:0]           grade_q;
  logic [IDX_W-1:0]     combo_q;
  logic [IDX_W-1:0]     max_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 busy_q;
  logic                 done_q;

  logic [E_W-1:0]       t_e;
  logic [E_W-1:0]       pw;
  logic [E_W-1:0]       gw;
  logic [E_W-1:0]       err;
  logic                 early;
  logic                 late;
  logic                 key_ok;
  logic                 hit_live;
  logic                 judge_now;
  logic [1:0]           grade_d;

  logic [IDX_W-1:0]     combo_inc;
  logic [IDX_W-1:0]     combo_d;
  logic [IDX_W-1:0]     max_d;
  logic [S1_W-1:0]      bonus;
  logic [S1_W-1:0]      pts;
  logic [S1_W-1:0]      sum;
  logic [SCORE_W-1:0]   score_d;
  logic [T_W-1:0]       gap_d;
  logic [IDX_W-1:0]     idx_d;

  // Timing window classification of the current hit against the registered t.
  always_comb begin
    t_e       = E_W'(t_q);
    pw        = PWIN_E >> difficulty;
    gw        = GWIN_E >> difficulty;
    err       = (t_e >= LEAD_E) ? (t_e - LEAD_E) : (LEAD_E - t_e);
    early     = (t_e + gw) < LEAD_E;
    late      = t_e > (LEAD_E + gw);
    key_ok    = (hit_key == note_q) && (hit_octave == oct_q);
    // A hit before the window opens is dropped; from the window start on,
    // any hit ends the note, and it wins over a simultaneous timeout.
    hit_live  = hit && !early;
    judge_now = (state_q == S_WAIT) && (hit_live || late);
    grade_d   = GR_MISS;
    if (hit_live && key_ok) begin
      if (err <= pw) begin
        grade_d = GR_PERFECT;
      end else if (err <= gw) begin
        grade_d = GR_GOOD;
      end
    end
  end

  // Next score/combo values for a judgement, plus the GAP load and next index.
  always_comb begin
    combo_inc = (combo_q == '1) ? combo_q : combo_q + IDX_W'(1);
    combo_d   = (grade_d == GR_MISS) ? '0 : combo_inc;
    max_d     = (combo_d > max_q) ? combo_d : max_q;
    // Bonus uses the combo before this perfect is counted.
    bonus     = (S1_W'(combo_q) > CAP_S) ? CAP_S : S1_W'(combo_q);
    pts       = '0;
    if (grade_d == GR_PERFECT) begin
      pts = S1_W'(PERFECT_PTS) + bonus;
    end else if (grade_d == GR_GOOD) begin
      pts = S1_W'(GOOD_PTS);
    end
    sum       = S1_W'(score_q) + pts;
    score_d   = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    gap_d     = T_W'(nlen_q) * T_W'(LEN_UNIT);
    idx_d     = idx_q + IDX_W'(1);
  end

  // Sequencer: state, note latch, timers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      note_q   <= '0;
      oct_q    <= '0;
      nlen_q   <= '0;
      t_q      <= '0;
      gap_q    <= '0;
      rd_req_q <= 1'b0;
      led_q    <= '0;
      jv_q     <= 1'b0;
      grade_q  <= GR_MISS;
      combo_q  <= '0;
      max_q    <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      jv_q <= 1'b0;
      if (!en) begin
        // Dropping en abandons the song from any state without a judgement.
        state_q  <= S_IDLE;
        idx_q    <= '0;
        rd_req_q <= 1'b0;
        led_q    <= '0;
        grade_q  <= GR_MISS;
        combo_q  <= '0;
        max_q    <= '0;
        score_q  <= '0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            idx_q <= '0;
            len_q <= song_len;
            if (song_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              rd_req_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          S_FETCH: begin
            if (rd_valid) begin
              note_q   <= rd_note;
              oct_q    <= rd_octave;
              nlen_q   <= rd_length;
              t_q      <= '0;
              rd_req_q <= 1'b0;
              led_q    <= rd_note;
              state_q  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (judge_now) begin
              jv_q    <= 1'b1;
              grade_q <= grade_d;
              combo_q <= combo_d;
              max_q   <= max_d;
              score_q <= score_d;
              led_q   <= '0;
              gap_q   <= gap_d;
              state_q <= S_GAP;
            end else if (tick && (t_q != '1)) begin
              t_q <= t_q + T_W'(1);
            end
          end
          S_GAP: begin
            if (gap_q == '0) begin
              idx_q <= idx_d;
              if (idx_d == len_q) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q  <= S_FETCH;
                rd_req_q <= 1'b1;
              end
            end else if (tick) begin
              gap_q <= gap_q - T_W'(1);
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_idx      = idx_q;
  assign note_led    = led_q;
  assign judge_valid = jv_q;
  assign judge_grade = grade_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign score       = score_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_play_judge.sv
// Bench for play_judge: the stimulus script doubles as the reference
// timeline, predicting every output after each clock edge from the
// judging/scoring rules; a negedge process compares the DUT each cycle.
module tb_play_judge;
  localparam int KEYS = 7, OCT_W = 2, LEN_W = 3, IDX_W = 8, SCORE_W = 21;
  localparam int LEAD = 64, LEN_UNIT = 16, PERFECT_WIN = 4, GOOD_WIN = 16;
  localparam int SMAX = (1 << SCORE_W) - 1;
  localparam int CMAX = (1 << IDX_W) - 1;

  logic clk = 1'b0;
  logic rst_n, en, tick, rd_valid, hit;
  logic [1:0] difficulty;
  logic [IDX_W-1:0] song_len;
  logic [KEYS-1:0] rd_note, hit_key;
  logic [OCT_W-1:0] rd_octave, hit_octave;
  logic [LEN_W-1:0] rd_length;
  logic rd_req, judge_valid, busy, done;
  logic [IDX_W-1:0] rd_idx, combo, max_combo;
  logic [KEYS-1:0] note_led;
  logic [1:0] judge_grade;
  logic [SCORE_W-1:0] score;

  play_judge dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .difficulty(difficulty),
    .song_len(song_len), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_note(rd_note), .rd_octave(rd_octave), .rd_length(rd_length),
    .hit(hit), .hit_key(hit_key), .hit_octave(hit_octave), .note_led(note_led),
    .judge_valid(judge_valid), .judge_grade(judge_grade), .combo(combo),
    .max_combo(max_combo), .score(score), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0, err_cnt = 0, dut_jv_cnt = 0;
  bit chk_en = 0;
  // e_*: expected now (after the last edge); n_*: expected after the next edge
  int e_rd_req, e_rd_idx, e_led, e_jv, e_grade, e_combo, e_max, e_score, e_busy, e_done;
  int n_rd_req, n_rd_idx, n_led, n_jv, n_grade, n_combo, n_max, n_score, n_busy, n_done;
  int p_key[32], p_oct[32], p_len[32], p_hit[32], p_mk[32], p_mo[32], p_early[32];
  int last_t;

  task automatic chk(input string nm, input int act, input int expv);
    cmp_cnt++;
    if (act != expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of every output against the expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_req", int'(rd_req), e_rd_req);
      if (e_rd_req != 0) chk("rd_idx", int'(rd_idx), e_rd_idx);
      chk("note_led", int'(note_led), e_led);
      chk("judge_valid", int'(judge_valid), e_jv);
      chk("judge_grade", int'(judge_grade), e_grade);
      chk("combo", int'(combo), e_combo);
      chk("max_combo", int'(max_combo), e_max);
      chk("score", int'(score), e_score);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      if (judge_valid) dut_jv_cnt++;
    end
  end

  task automatic clear_next();
    n_rd_req = 0; n_rd_idx = 0; n_led = 0; n_jv = 0; n_grade = 0;
    n_combo = 0; n_max = 0; n_score = 0; n_busy = 0; n_done = 0;
  endtask

  task automatic clear_all();
    clear_next();
    e_rd_req = 0; e_rd_idx = 0; e_led = 0; e_jv = 0; e_grade = 0;
    e_combo = 0; e_max = 0; e_score = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    e_rd_req = n_rd_req; e_rd_idx = n_rd_idx; e_led = n_led; e_jv = n_jv;
    e_grade = n_grade; e_combo = n_combo; e_max = n_max; e_score = n_score;
    e_busy = n_busy; e_done = n_done;
    #1;
    n_jv = 0;
    hit = 1'b0; rd_valid = 1'b0; tick = 1'b0;
    hit_key = KEYS'(1 << $urandom_range(0, KEYS - 1));
    hit_octave = OCT_W'($urandom_range(0, 3));
    rd_note = KEYS'(1 << $urandom_range(0, KEYS - 1));
    rd_octave = OCT_W'($urandom_range(0, 3));
    rd_length = LEN_W'($urandom_range(0, 7));
  endtask

  function automatic int grade_of(input int t, input int gw, input int pw, input bit matched);
    int err;
    err = (t >= LEAD) ? t - LEAD : LEAD - t;
    if (!matched) return 0;
    if (err <= pw) return 2;
    if (err <= gw) return 1;
    return 0;
  endfunction

  task automatic apply_grade(input int g);
    int pts;
    n_jv = 1;
    n_grade = g;
    if (g == 0) n_combo = 0;
    else begin
      pts = (g == 2) ? 3 + ((n_combo < 15) ? n_combo : 15) : 1;
      n_score = (n_score + pts > SMAX) ? SMAX : n_score + pts;
      n_combo = (n_combo == CMAX) ? CMAX : n_combo + 1;
    end
    if (n_combo > n_max) n_max = n_combo;
  endtask

  task automatic set_note(input int i, input int key, input int oct, input int len,
                          input int ht, input int mk, input int mo, input int early);
    p_key[i] = key; p_oct[i] = oct; p_len[i] = len; p_hit[i] = ht;
    p_mk[i] = mk; p_mo[i] = mo; p_early[i] = early;
  endtask

  task automatic play_song(input int n, input int diff, input int tick_pct, input int abort_note);
    int gw, pw, t, rem, g, iter;
    bit hd, ed, judged, hm, tk;
    gw = GOOD_WIN >> diff;
    pw = PERFECT_WIN >> diff;
    difficulty = 2'(diff);
    song_len = IDX_W'(n);
    en = 1'b1;
    if (n == 0) n_done = 1;
    else begin n_busy = 1; n_rd_req = 1; n_rd_idx = 0; end
    cycle();
    song_len = IDX_W'($urandom_range(0, 255));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        hit = 1'($urandom_range(0, 1));
        tick = 1'($urandom_range(0, 1));
        cycle();
      end
      rd_valid = 1'b1;
      rd_note = KEYS'(1 << p_key[i]);
      rd_octave = OCT_W'(p_oct[i]);
      rd_length = LEN_W'(p_len[i]);
      n_rd_req = 0;
      n_led = 1 << p_key[i];
      cycle();
      t = 0; hd = 0; ed = 0; judged = 0; iter = 0;
      while (!judged) begin
        tk = ($urandom_range(0, 99) < tick_pct);
        tick = tk;
        rd_valid = ($urandom_range(0, 4) == 0);
        hm = 0;
        if (p_early[i] >= 0 && !ed && t == p_early[i]) begin
          ed = 1; hit = 1'b1; hm = 1;
          hit_key = KEYS'(1 << p_key[i]);
          hit_octave = OCT_W'(p_oct[i]);
        end else if (p_hit[i] >= 0 && !hd && t == p_hit[i]) begin
          hd = 1; hit = 1'b1; hm = (p_mk[i] != 0) && (p_mo[i] != 0);
          hit_key = KEYS'(1 << ((p_mk[i] != 0) ? p_key[i] : (p_key[i] + 1) % KEYS));
          hit_octave = OCT_W'((p_mo[i] != 0) ? p_oct[i] : (p_oct[i] ^ 1));
        end
        if (hit && i == abort_note) begin
          en = 1'b0;
          clear_next();
          cycle();
          return;
        end
        if (hit && t >= LEAD - gw) begin
          g = grade_of(t, gw, pw, hm);
          judged = 1;
        end else if (t > LEAD + gw) begin
          g = 0;
          judged = 1;
        end
        if (judged) begin
          apply_grade(g);
          n_led = 0;
          last_t = t;
        end
        cycle();
        if (!judged && tk) t++;
        iter++;
        if (iter > 4000) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL wait_bound: note %0d not judged within %0d cycles", i, iter);
          return;
        end
      end
      rem = p_len[i] * LEN_UNIT;
      forever begin
        tk = ($urandom_range(0, 99) < tick_pct);
        tick = tk;
        hit = 1'($urandom_range(0, 1));
        rd_valid = 1'($urandom_range(0, 1));
        if (rem == 0) begin
          if (i + 1 == n) begin n_done = 1; n_busy = 0; end
          else begin n_rd_req = 1; n_rd_idx = i + 1; end
          cycle();
          break;
        end
        cycle();
        if (tk) rem--;
      end
    end
    repeat (3) begin
      hit = 1'($urandom_range(0, 1));
      rd_valid = 1'($urandom_range(0, 1));
      tick = 1'($urandom_range(0, 1));
      cycle();
    end
  endtask

  task automatic end_song();
    en = 1'b0;
    clear_next();
    cycle();
    cycle();
  endtask

  int jv0, n, diff, gw;

  initial begin
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; rd_valid = 1'b0; hit = 1'b0;
    difficulty = 2'd0; song_len = '0; rd_note = '0; rd_octave = '0;
    rd_length = '0; hit_key = '0; hit_octave = '0; last_t = -1;
    clear_all();
    chk_en = 1;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // perfect, perfect, good
    set_note(0, 0, 1, 1, 64, 1, 1, -1);
    set_note(1, 0, 1, 1, 66, 1, 1, -1);
    set_note(2, 0, 1, 1, 80, 1, 1, -1);
    play_song(3, 0, 100, -1);
    chk("t1_score", int'(score), 8);
    chk("t1_combo", int'(combo), 3);
    chk("t1_max", int'(max_combo), 3);
    chk("t1_grade", int'(judge_grade), 1);
    end_song();

    // wrong key then a fresh perfect with no bonus
    set_note(0, 0, 1, 1, 64, 0, 1, -1);
    set_note(1, 0, 1, 0, 64, 1, 1, -1);
    play_song(2, 0, 100, -1);
    chk("t2_score", int'(score), 3);
    chk("t2_combo", int'(combo), 1);
    end_song();

    // timeout at difficulty 0
    set_note(0, 3, 2, 0, -1, 1, 1, -1);
    play_song(1, 0, 100, -1);
    chk("t3_miss_t", last_t, 81);
    chk("t3_grade", int'(judge_grade), 0);
    end_song();

    // difficulty 2: good at 66, then timeout at 69
    set_note(0, 2, 0, 0, 66, 1, 1, -1);
    set_note(1, 2, 0, 0, -1, 1, 1, -1);
    play_song(2, 2, 100, -1);
    chk("t3b_score", int'(score), 1);
    chk("t3b_miss_t", last_t, 69);
    chk("t3b_max", int'(max_combo), 1);
    end_song();

    // early hit ignored, single judgement
    jv0 = dut_jv_cnt;
    set_note(0, 5, 3, 0, 64, 1, 1, 40);
    play_song(1, 0, 100, -1);
    chk("t4_pulses", dut_jv_cnt - jv0, 1);
    chk("t4_grade", int'(judge_grade), 2);
    chk("t4_score", int'(score), 3);
    end_song();

    // 20 perfects then a miss: bonus caps at 15
    for (int i = 0; i < 20; i++) set_note(i, i % KEYS, i % 4, 0, 64, 1, 1, -1);
    set_note(20, 1, 1, 0, -1, 1, 1, -1);
    play_song(21, 0, 100, -1);
    chk("t5_score", int'(score), 240);
    chk("t5_max", int'(max_combo), 20);
    chk("t5_combo", int'(combo), 0);
    end_song();

    // empty song
    play_song(0, 0, 100, -1);
    chk("t6_done", int'(done), 1);
    end_song();

    // en dropped in WAIT with a hit in the same cycle
    set_note(0, 4, 1, 0, 64, 1, 1, -1);
    set_note(1, 4, 1, 0, 64, 1, 1, -1);
    play_song(2, 0, 100, 1);
    cycle();
    chk("t7_score", int'(score), 0);

    // async reset mid-FETCH
    difficulty = 2'd0; song_len = IDX_W'(2); en = 1'b1;
    n_busy = 1; n_rd_req = 1; n_rd_idx = 0;
    cycle();
    cycle();
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("t8_rst_rd_req", int'(rd_req), 0);
    chk("t8_rst_busy", int'(busy), 0);
    clear_all();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // randomized songs
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 6);
      diff = $urandom_range(0, 3);
      gw = GOOD_WIN >> diff;
      for (int i = 0; i < n; i++) begin
        set_note(i, $urandom_range(0, KEYS - 1), $urandom_range(0, 3), $urandom_range(0, 7),
                 ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(LEAD - gw - 3, LEAD + gw + 2),
                 ($urandom_range(0, 5) != 0) ? 1 : 0, ($urandom_range(0, 5) != 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, LEAD - gw - 1) : -1);
      end
      play_song(n, diff, $urandom_range(40, 100), -1);
      end_song();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/play_judge.md
# play_judge

Parametrised rhythm-game judging engine, the successor to the fixed play-mode scorer. It fetches goal notes one at a time from a song store through a request/valid handshake and presents each goal key on the LEDs. It grades the player's hit against a timing window around the note's target time (perfect / good / miss) and accumulates score, combo and max-combo. It sits between the song ROM / key debouncers and the scoreboard / tube display driver.

## Interface
Parameters:
- KEYS, 7: number of note keys; goal note and hit key use this many bits (one-hot).
- OCT_W, 2: octave field width.
- LEN_W, 3: note-length field width.
- IDX_W, 8: song note index width.
- T_W, 16: per-note tick timer width.
- LEAD, 64: ticks from note presentation to target time.
- LEN_UNIT, 16: ticks per length unit after judgement.
- PERFECT_WIN, 4: base perfect half-window, in ticks.
- GOOD_WIN, 16: base good half-window, in ticks (≥ PERFECT_WIN).
- PERFECT_PTS, 3: base points for a perfect.
- GOOD_PTS, 1: points for a good.
- COMBO_CAP, 15: maximum combo bonus added per perfect.
- SCORE_W, 21: score width.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- en, in, 1: play enable; low forces IDLE and clears all results.
- tick, in, 1: one-cycle time-base strobe.
- difficulty, in, 2: effective windows = base window >> difficulty.
- song_len, in, IDX_W: number of notes; sampled on the cycle the FSM leaves IDLE.
- rd_req, out, 1: fetch request.
- rd_idx, out, IDX_W: note index to fetch.
- rd_valid, in, 1: fetch data valid.
- rd_note, in, KEYS: goal key, one-hot.
- rd_octave, in, OCT_W: goal octave.
- rd_length, in, LEN_W: goal length.
- hit, in, 1: one-cycle press pulse.
- hit_key, in, KEYS: pressed key, one-hot.
- hit_octave, in, OCT_W: current octave.
- note_led, out, KEYS: goal key of the current note, 0 when not in WAIT.
- judge_valid, out, 1: one-cycle judgement pulse.
- judge_grade, out, 2: 0 = miss, 1 = good, 2 = perfect; holds its value until the next judgement.
- combo, out, IDX_W: current combo.
- max_combo, out, IDX_W: maximum combo reached.
- score, out, SCORE_W: accumulated score.
- busy, out, 1: high in any state other than IDLE or DONE.
- done, out, 1: high in DONE.

## Operation
- States:
  - IDLE: en rising (sampled high) → FETCH. Sets idx = 0 and latches song_len. If the latched song_len = 0, go straight to DONE.
  - FETCH: rd_req = 1, rd_idx = idx. On rd_valid, latch the note fields, clear t, go to WAIT. rd_req and rd_idx stay stable until rd_valid.
  - WAIT: t increments on each tick and saturates at all-ones. Define err = |t − LEAD|, Pw = PERFECT_WIN >> difficulty, Gw = GOOD_WIN >> difficulty.
  - GAP: counts rd_length × LEN_UNIT ticks, then idx + 1. If the new idx = song_len, go to DONE; otherwise go to FETCH. rd_length = 0 leaves GAP on the next cycle.
  - DONE: holds all results until en is low.
- Judging in WAIT:
  - hit with t < LEAD − Gw: ignored.
  - hit with hit_key ≠ rd_note or hit_octave ≠ rd_octave, within or after the window start: miss.
  - hit with matching key and octave, err ≤ Pw: perfect.
  - hit with matching key and octave, Pw < err ≤ Gw: good.
  - t > LEAD + Gw with no hit: miss.
  - Every judgement pulses judge_valid and moves to GAP.
- Scoring:
  - perfect: combo + 1, score += PERFECT_PTS + min(old combo, COMBO_CAP).
  - good: combo + 1, score += GOOD_PTS.
  - miss: combo = 0.
  - max_combo = max(max_combo, new combo).
  - score saturates at all-ones. combo saturates at all-ones.
- en low in any state: next cycle IDLE. score, combo, max_combo, judge_grade and idx cleared; no judge_valid pulse.

## Timing
- Reset values: all outputs 0, state IDLE.
- The hit decision uses the t value registered in that cycle. judge_valid, judge_grade, score and combo all update on the same edge, 1 cycle after the hit is sampled.
- A hit and the timeout in the same cycle: the hit is judged and the timeout is ignored.
- A tick in the judging cycle does not change the grade.
- rd_valid while not in FETCH is ignored.
- hit outside WAIT is ignored.
- A 0→1 transition of note_led occurs the cycle after rd_valid is accepted.

## Test plan
- Defaults, difficulty 0, song_len 3, all notes key 0000001, octave 1, length 1. Hits at t = 64, 66, 80 → grades 2, 2, 1. Scores 3, 7, 8; combo 3; done after 3 GAPs.
- Wrong key 0000010 at t = 64 → grade 0, combo 0. Then a correct hit at t = 64 on the next note → score += 3 (bonus 0).
- No hit → miss pulse at t = 81. With difficulty 2 (Gw = 4), the miss pulse is at t = 69, and a hit at t = 66 grades 1.
- Hit at t = 40 (early, ignored), then at t = 64 → single judgement, perfect.
- 20 consecutive perfects → bonus caps at 15. max_combo = 20, held after a miss resets combo.
- song_len = 0 → DONE with no rd_req. Drop en in WAIT → IDLE next cycle, all results 0. rst_n low mid-FETCH → rd_req 0 immediately.
